// File: rtl/pwm_pkg.sv
// Shared PWM definitions: default counter/measurement width and capture FSM states.
// Used by both the PWM generator and pwm_capture; no build options apply here.
package pwm_pkg;

  localparam int PWM_MAX_WAVE = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pwm_in_cond.sv
// PWM pin conditioning: 2-flop synchronizer, optional 3-sample glitch filter (PWM_CAPTURE_FILTER_EN), edge detect.
// Edge flags are consumed 2 cycles after a pin change (4 with the filter); no backpressure.
module pwm_in_cond (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       sync0;
  logic       sync1;
  logic       level_q;
  logic [2:0] warm;
  logic       primed;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0 <= 1'b0;
      sync1 <= 1'b0;
    end else begin
      sync0 <= pwm_in;
      sync1 <= sync0;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam logic [2:0] WARM_CYCLES = 3'd5;

  logic [1:0] hist;
  logic [2:0] win;

  // Window = newest synchronized sample plus the two before it.
  assign win = {hist, sync1};

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], sync1};
    end
  end

  always_comb begin
    level = level_q;
    if (win == 3'b111) begin
      level = 1'b1;
    end else if (win == 3'b000) begin
      level = 1'b0;
    end
  end
`else
  localparam logic [2:0] WARM_CYCLES = 3'd3;

  assign level = sync1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level;
    end
  end

  // Reset zeroes the pipeline, so a pin that is already high would look like a rise;
  // edges are held off until every stage again holds a real pin sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm <= 3'd0;
    end else if (warm != WARM_CYCLES) begin
      warm <= warm + 3'd1;
    end
  end

  assign primed = (warm == WARM_CYCLES);
  assign rise   = primed & level & ~level_q;
  assign fall   = primed & ~level & level_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period/high-time capture; filter selected by PWM_CAPTURE_FILTER_EN in pwm_in_cond.
// Results land with a one-cycle valid one cycle after the consumed rise; no backpressure.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int MAX_WAVE = PWM_MAX_WAVE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic [MAX_WAVE-1:0] period,
  output logic [MAX_WAVE-1:0] high_time,
  output logic                valid,
  output logic                timeout
);

  localparam logic [MAX_WAVE-1:0] CNT_MAX = '1;
  localparam logic [MAX_WAVE-1:0] CNT_ONE = MAX_WAVE'(1);

  pwm_state_t          state;
  pwm_state_t          state_nxt;
  logic [MAX_WAVE-1:0] cnt;
  logic [MAX_WAVE-1:0] cnt_nxt;
  logic [MAX_WAVE-1:0] hi_lat;
  logic [MAX_WAVE-1:0] hi_lat_nxt;
  logic [MAX_WAVE-1:0] period_nxt;
  logic [MAX_WAVE-1:0] high_time_nxt;
  logic                valid_nxt;
  logic                timeout_nxt;
  logic                level_unused;
  logic                rise;
  logic                fall;

  // Capture works from edge flags only; the conditioned level is for other consumers.
  pwm_in_cond u_cond (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .level  (level_unused),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_lat    <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      hi_lat    <= hi_lat_nxt;
      period    <= period_nxt;
      high_time <= high_time_nxt;
      valid     <= valid_nxt;
      timeout   <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    hi_lat_nxt    = hi_lat;
    period_nxt    = period;
    high_time_nxt = high_time;
    valid_nxt     = 1'b0;
    timeout_nxt   = timeout;

    case (state)
      // Falls seen here belong to a partial pulse and are dropped.
      IDLE: begin
        if (rise) begin
          cnt_nxt   = CNT_ONE;
          state_nxt = HIGH;
        end
      end

      HIGH: begin
        if (fall) begin
          hi_lat_nxt = cnt;
          cnt_nxt    = cnt + CNT_ONE;
          state_nxt  = LOW;
        end else if (cnt == CNT_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      LOW: begin
        if (rise) begin
          period_nxt    = cnt;
          high_time_nxt = hi_lat;
          valid_nxt     = 1'b1;
          timeout_nxt   = 1'b0;
          cnt_nxt       = CNT_ONE;
          state_nxt     = HIGH;
        end else if (cnt == CNT_MAX) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture (MAX_WAVE=8): per-cycle reference model plus directed literal checks and random waveforms.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int MAXC = (1 << W) - 1;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif
  localparam int WARM = FILT ? 5 : 3;
  localparam int H29  = FILT ? 3 : 1;
  localparam int H31  = FILT ? 3 : 2;
  localparam int L31  = 8 - H31;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         timeout;

  pwm_capture #(.MAX_WAVE(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Reference model: the pin seen through a pure delay (or a 3-agree filter),
  // edges ignored for WARM cycles after reset, measurements from edge timestamps.
  bit p1 = 0, p2 = 0, p3 = 0, c1 = 0, c2 = 0;
  int since = 0;
  int phase = 0;
  int t_rise = 0;
  int hi_m = 0;
  int m_period = 0;
  int m_high = 0;
  bit m_valid = 0;
  bit m_timeout = 0;

  always @(posedge clk) begin
    bit rise_e;
    bit fall_e;
    bit c_now;
    cyc++;
    if (rst) begin
      p1 = 0; p2 = 0; p3 = 0; c1 = 0; c2 = 0;
      since = 0; phase = 0; t_rise = 0; hi_m = 0;
      m_period = 0; m_high = 0; m_valid = 0; m_timeout = 0;
    end else begin
      rise_e  = (since >= WARM) && c1 && !c2;
      fall_e  = (since >= WARM) && !c1 && c2;
      m_valid = 0;
      case (phase)
        0: if (rise_e) begin t_rise = cyc; phase = 1; end
        1: begin
          if (fall_e) begin
            hi_m = cyc - t_rise; phase = 2;
          end else if (cyc - t_rise == MAXC) begin
            m_timeout = 1; phase = 0;
          end
        end
        default: begin
          if (rise_e) begin
            m_period = cyc - t_rise; m_high = hi_m; m_valid = 1; m_timeout = 0;
            t_rise = cyc; phase = 1;
          end else if (cyc - t_rise == MAXC) begin
            m_timeout = 1; phase = 0;
          end
        end
      endcase
      c_now = FILT ? ((p1 == p2 && p2 == p3) ? p1 : c1) : p1;
      p3 = p2; p2 = p1; p1 = pwm_in;
      c2 = c1; c1 = c_now;
      since++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      total++;
      if (valid !== m_valid || timeout !== m_timeout ||
          period !== W'(m_period) || high_time !== W'(m_high)) begin
        bad++;
        $display("FAIL model cyc=%0d valid=%b/%b timeout=%b/%b period=%0d/%0d high_time=%0d/%0d (got/want)",
                 cyc, valid, m_valid, timeout, m_timeout, period, m_period, high_time, m_high);
      end
    end
  end

  // Valid-event monitor used by the literal checks.
  int vcnt = 0;
  int last_vcyc = 0;
  int vgap = 0;
  int lp = 0;
  int lh = 0;
  int min_p = 255;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcnt++;
      vgap = cyc - last_vcyc;
      last_vcyc = cyc;
      lp = int'(period);
      lh = int'(high_time);
      if (int'(period) < min_p) min_p = int'(period);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      pwm_in = v;
    end
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, l);
    end
  endtask

  task automatic do_reset(input bit v, input int n);
    @(negedge clk); #1;
    rst = 1'b1;
    pwm_in = v;
    for (int i = 1; i < n; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    rst = 1'b0;
  endtask

  int r;
  int v0;

  initial begin
    // Reset state
    do_reset(1'b0, 2);
    chk_en = 1'b1;
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high_time), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);

    // H=3 L=5: nothing before the second rise, then period 8 / high 3 every 8 cycles
    vcnt = 0;
    wave(3, 5, 1);
    chk("h3l5_no_early_valid", vcnt, 0);
    wave(3, 5, 5);
    chk("h3l5_count", vcnt, 5);
    chk("h3l5_period", lp, 8);
    chk("h3l5_high", lh, 3);
    chk("h3l5_gap", vgap, 8);

    // Minimum waveform (H=1 L=1 unfiltered)
    vcnt = 0;
    wave(H29, H29, 10);
    drive(1'b0, 4);
    chk("min_count", vcnt, 10);
    chk("min_period", lp, 2 * H29);
    chk("min_high", lh, H29);
    chk("min_gap", vgap, 2 * H29);

    // Hold low until the counter saturates
    v0 = vcnt;
    drive(1'b0, 240);
    chk("to_not_yet", int'(timeout), 0);
    drive(1'b0, 60);
    chk("to_set", int'(timeout), 1);
    chk("to_period_held", int'(period), 2 * H29);
    chk("to_high_held", int'(high_time), H29);
    chk("to_no_valid", vcnt, v0);
    wave(4, 4, 1);
    chk("to_first_rise_no_valid", vcnt, v0);
    chk("to_still_set", int'(timeout), 1);
    wave(4, 4, 2);
    chk("to_resume_count", vcnt, v0 + 2);
    chk("to_cleared", int'(timeout), 0);
    chk("to_resume_period", lp, 8);
    chk("to_resume_high", lh, 4);

    // Start with pin high: first fall ignored
    do_reset(1'b1, 2);
    vcnt = 0;
    drive(1'b1, 5);
    drive(1'b0, 4);
    wave(H31, L31, 1);
    chk("hi_start_no_valid", vcnt, 0);
    wave(H31, L31, 2);
    chk("hi_start_count", vcnt, 2);
    chk("hi_start_period", lp, 8);
    chk("hi_start_high", lh, H31);

    // Reset mid-HIGH of H=5 L=5
    wave(5, 5, 2);
    drive(1'b1, 4);
    do_reset(1'b1, 1);
    chk("midrst_period", int'(period), 0);
    chk("midrst_high", int'(high_time), 0);
    chk("midrst_valid", int'(valid), 0);
    chk("midrst_timeout", int'(timeout), 0);
    vcnt = 0;
    drive(1'b0, 5);
    wave(5, 5, 1);
    chk("midrst_one_rise", vcnt, 0);
    wave(5, 5, 2);
    chk("midrst_count", vcnt, 2);
    chk("midrst_period10", lp, 10);
    chk("midrst_high5", lh, 5);

    // 1-cycle glitch inside the low phase of H=10 L=10
    wave(10, 10, 2);
    min_p = 255;
    drive(1'b1, 10);
    drive(1'b0, 4);
    drive(1'b1, 1);
    drive(1'b0, 5);
    wave(10, 10, 2);
    chk("glitch_short_period", int'(min_p < 20), FILT ? 0 : 1);
    chk("glitch_period", lp, 20);
    chk("glitch_high", lh, 10);

    // Random waveforms, long holds, glitches and resets against the model
    for (int s = 0; s < 160; s++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do_reset(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      end else if (r < 8) begin
        drive(1'($urandom_range(0, 1)), $urandom_range(250, 300));
      end else if (r < 20) begin
        drive(1'($urandom_range(0, 1)), $urandom_range(1, 2));
      end else begin
        wave($urandom_range(1, 15), $urandom_range(1, 15), $urandom_range(1, 3));
      end
    end
    drive(1'b0, 10);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
